// File: rtl/pipe_muldiv_ctrl.sv
// pipe_muldiv_ctrl: iterative MIPS-style mul/div unit with HI/LO registers.
// Ports: clk, rst_n (async low), start/op/a/b request, flush abort,
//        busy (stall), done (result pulse), hi/lo register contents.
module pipe_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int W = XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]     state;
    logic [4:0]     cnt;
    logic           is_div;
    logic           is_sgn;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc;
    logic           neg_q;
    logic           neg_r;
    logic           dz;
    logic           done_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic [W:0]     msum;
    logic [2*W-1:0] mul_nxt;
    logic [W:0]     rsh;
    logic [W:0]     dif;
    logic           dq;
    logic [2*W-1:0] div_nxt;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;

    assign busy = (state != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        abs_a = (is_sgn && ra[W-1]) ? -ra : ra;
        abs_b = (is_sgn && rb[W-1]) ? -rb : rb;

        // Multiply: multiplier sits in the low half and is shifted out
        // while the partial product grows into the high half.
        msum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt = {msum, acc[W-1:1]};

        // Restoring divide: remainder high, quotient bits enter at bit 0.
        rsh     = {acc[2*W-1:W], acc[W-1]};
        dif     = rsh - {1'b0, opnd};
        dq      = ~dif[W];
        div_nxt = {(dq ? dif[W-1:0] : rsh[W-1:0]), acc[W-2:0], dq};

        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[W-1:0] : acc[W-1:0];
        rem  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

        fix_hi = prod[2*W-1:W];
        fix_lo = prod[W-1:0];
        if (is_div) begin
            fix_hi = rem;
            fix_lo = quo;
            // Zero divisor: fixed all-ones quotient, raw dividend remainder.
            if (dz) begin
                fix_hi = ra;
                fix_lo = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            ra     <= '0;
            rb     <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !flush) begin
                            if (!op[2]) begin
                                is_div <= op[1];
                                is_sgn <= ~op[0];
                                ra     <= a;
                                rb     <= b;
                                state  <= S_PREP;
                            end else if (op[1:0] == 2'b00) begin
                                hi_q <= a;
                            end else if (op[1:0] == 2'b01) begin
                                lo_q <= a;
                            end
                        end
                    end
                    S_PREP: begin
                        opnd  <= is_div ? abs_b : abs_a;
                        acc   <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
                        neg_q <= is_sgn & (ra[W-1] ^ rb[W-1]);
                        neg_r <= is_sgn & ra[W-1];
                        dz    <= is_div & (rb == '0);
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                    S_CALC: begin
                        acc <= is_div ? div_nxt : mul_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= S_FIX;
                    end
                    S_FIX: begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// tb_pipe_muldiv_ctrl: vector table, hand sequences and random ops
// checked against an arithmetic reference model.
module tb_pipe_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_muldiv_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] mop,
                                          input logic [31:0] ma,
                                          input logic [31:0] mb);
        longint          sa = longint'($signed(ma));
        longint          sb = longint'($signed(mb));
        longint unsigned ua = {32'b0, ma};
        longint unsigned ub = {32'b0, mb};
        longint          sq;
        longint          sr;
        logic [63:0]     r;
        r = '0;
        case (mop)
            3'd0: r = sa * sb;
            3'd1: r = ua * ub;
            3'd2: begin
                if (mb == 0) r = {ma, 32'hFFFFFFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (mb == 0) r = {ma, 32'hFFFFFFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue an op, then check exact busy/done timing and the result.
    task automatic run_op(input string name, input logic [2:0] rop,
                          input logic [31:0] ra, input logic [31:0] rb,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int bcnt = 0;
        int dcnt = 0;
        int dcyc = -1;
        @(negedge clk);
        start = 1'b1;
        op = rop;
        a = ra;
        b = rb;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
        end
        chk({name, " done_cycle"}, 32'(dcyc), 32'd35);
        chk({name, " done_pulses"}, 32'(dcnt), 32'd1);
        chk({name, " busy_cycles"}, 32'(bcnt), 32'd34);
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
    endtask

    vec_t vt[$];

    initial begin
        logic [31:0] phi;
        logic [31:0] plo;
        logic [63:0] m;
        int dn;

        vt.push_back('{3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB});
        vt.push_back('{3'd3, 32'd100, 32'd7, 32'd2, 32'd14});
        vt.push_back('{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vt.push_back('{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF});
        vt.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000});
        vt.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1});
        vt.push_back('{3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD});
        vt.push_back('{3'd2, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF});
        vt.push_back('{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0});
        vt.push_back('{3'd1, 32'd6, 32'd7, 32'd0, 32'd42});

        #12;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // MTHI / MTLO while idle
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h12345678;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("mthi hi", hi, 32'h12345678);
        chk("mthi busy", {31'b0, busy}, 32'd0);
        chk("mthi done", {31'b0, done}, 32'd0);
        start = 1'b1; op = 3'd5; a = 32'hCAFEF00D;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("mtlo lo", lo, 32'hCAFEF00D);
        chk("mtlo hi", hi, 32'h12345678);

        // Reserved op is ignored
        start = 1'b1; op = 3'd6; a = 32'h0BADBEEF;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("op6 busy", {31'b0, busy}, 32'd0);
        chk("op6 hi", hi, 32'h12345678);
        chk("op6 lo", lo, 32'hCAFEF00D);

        foreach (vt[i])
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                   vt[i].ehi, vt[i].elo);

        // Flush in cycle N+10 of MULTU
        phi = hi;
        plo = lo;
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy_after", {31'b0, busy}, 32'd0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("flush no_done", 32'(dn), 32'd0);
        chk("flush hi_kept", hi, phi);
        chk("flush lo_kept", lo, plo);
        run_op("post_flush multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'd1);

        // MTLO during a busy DIVU is ignored
        plo = lo;
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hDEADDEAD;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("busy_mtlo lo_kept", lo, plo);
        dn = 0;
        for (int c = 0; c < 40 && dn == 0; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("busy_mtlo done_seen", 32'(dn), 32'd1);
        chk("busy_mtlo lo", lo, 32'd14);
        chk("busy_mtlo hi", hi, 32'd2);

        // Reset in cycle N+20 of MULT
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h00001234; b = 32'hFFFF0001;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op("post_rst multu", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            m = model(rop, ra, rb);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb,
                   m[63:32], m[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
